key_event_queue: RTL

Parametrised PS/2 keyboard front end. It pops raw scancode bytes from `ps2_keyboard`, decodes `F0` (break) and `E0` (extended) prefixes, and tracks the shift, ctrl and caps-lock state. Each keypress is translated to ASCII through a registered scancode map. The resulting key events go into a show-ahead FIFO with a valid/ready drain, giving software typeahead instead of a single-character latch. It sits between `ps2_keyboard` and the bus-facing keyboard register.

---
 rtl/key_event_queue_pkg.sv | 46 ++++
 rtl/key_event_queue_if.sv | 13 +
 rtl/key_event_queue_scan_map.sv | 43 ++++
 rtl/key_event_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/key_event_queue_pkg.sv
// key_pkg: shared definitions for the key_event_queue keyboard front end.
//   - decoder FSM state enum
//   - PS/2 set-2 scancode constants (prefixes and modifier keys)
//   - bit positions inside the 13-bit key event word
//   - ASCII bounds and case-conversion constants, plus the ASCII transform
package key_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_LOOK,
    S_EMIT
  } state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int EV_BRK_BIT   = 8;
  localparam int EV_EXT_BIT   = 9;
  localparam int EV_SHIFT_BIT = 10;
  localparam int EV_CTRL_BIT  = 11;
  localparam int EV_CAPS_BIT  = 12;
  localparam int EV_W         = 13;

  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
  localparam logic [7:0] CTRL_MASK   = 8'h1F;

  // Only lower-case letters are affected; ctrl wins over shift/caps.
  function automatic logic [7:0] xform_ascii(input logic [7:0] a, input logic shift,
                                             input logic ctrl, input logic caps);
    logic [7:0] r;
    r = a;
    if (a >= ASCII_LO && a <= ASCII_HI) begin
      if (ctrl)              r = a & CTRL_MASK;
      else if (shift ^ caps) r = a - CASE_OFFSET;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// key_event_queue_if: valid/ready drain port of the key event FIFO.
//   ev_data  : head event word (zero when empty)
//   ev_valid : FIFO not empty
//   ev_ready : consumer pops the head when ev_valid & ev_ready
// master = event producer (the queue), slave = consumer.
interface key_event_queue_if #(parameter int OUT_W = 32);
  logic [OUT_W-1:0] ev_data;
  logic             ev_valid;
  logic             ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/key_event_queue_scan_map.sv
// key_scan_map: 256x8 scancode -> lower-case ASCII ROM, registered output
// (1-cycle latency). Unmapped codes return 0.
//   clk   : clock
//   en    : load the output register from the ROM
//   code  : scancode address
//   ascii : registered ASCII value
module key_scan_map (
  input  logic       clk,
  input  logic       en,
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  logic [7:0] rom_d;
  logic [7:0] ascii_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rom_d = 8'h00;
    case (code)
      8'h1C: rom_d = "a";  8'h32: rom_d = "b";  8'h21: rom_d = "c";  8'h23: rom_d = "d";
      8'h24: rom_d = "e";  8'h2B: rom_d = "f";  8'h34: rom_d = "g";  8'h33: rom_d = "h";
      8'h43: rom_d = "i";  8'h3B: rom_d = "j";  8'h42: rom_d = "k";  8'h4B: rom_d = "l";
      8'h3A: rom_d = "m";  8'h31: rom_d = "n";  8'h44: rom_d = "o";  8'h4D: rom_d = "p";
      8'h15: rom_d = "q";  8'h2D: rom_d = "r";  8'h1B: rom_d = "s";  8'h2C: rom_d = "t";
      8'h3C: rom_d = "u";  8'h2A: rom_d = "v";  8'h1D: rom_d = "w";  8'h22: rom_d = "x";
      8'h35: rom_d = "y";  8'h1A: rom_d = "z";
      8'h45: rom_d = "0";  8'h16: rom_d = "1";  8'h1E: rom_d = "2";  8'h26: rom_d = "3";
      8'h25: rom_d = "4";  8'h2E: rom_d = "5";  8'h36: rom_d = "6";  8'h3D: rom_d = "7";
      8'h3E: rom_d = "8";  8'h46: rom_d = "9";
      8'h29: rom_d = " ";  8'h5A: rom_d = 8'h0D; 8'h66: rom_d = 8'h08;
      default: rom_d = 8'h00;
    endcase
  end

  // Loaded before every use by the decoder, so it needs no reset.
  always_ff @(posedge clk) begin
    if (en) ascii_q <= rom_d;
  end

  assign ascii = ascii_q;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: PS/2 scancode decoder + show-ahead key event FIFO.
// Pops bytes from ps2_keyboard, handles F0/E0 prefixes, tracks shift/ctrl/caps,
// maps keys to ASCII and queues 13-bit events (zero-extended to OUT_W).
//   sys_clk, clrn (sync, active-low)
//   code_data/code_ready in, code_next_n out : receiver pop handshake
//   ev_if (master)                           : event drain (data/valid/ready)
//   fifo_count, overflow (sticky), caps_lock : status
// Build option: define KEY_BREAK_EVENTS_EN to also queue break events of
// non-modifier keys (bit 8 set); otherwise breaks only update modifiers.
module key_event_queue
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OUT_W      = 32
) (
  input  logic                          sys_clk,
  input  logic                          clrn,
  input  logic [7:0]                    code_data,
  input  logic                          code_ready,
  output logic                          code_next_n,
  key_event_queue_if.master             ev_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          caps_lock
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       brk_q, brk_d, ext_q, ext_d;
  logic       shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d;
  logic       code_next_n_q, code_next_n_d;
  logic       map_en;
  logic [7:0] map_ascii, ev_ascii;
  logic       is_shift, is_ctrl, is_caps, is_mod;
  logic       push_req;
  logic [EV_W-1:0] ev_word;

  logic [EV_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CW-1:0]   count_q, count_d;
  logic [EV_W-1:0] head_q, head_d;
  logic            valid_q, valid_d, overflow_q, overflow_d;
  logic            pop, push_ok;

  key_scan_map u_map (
    .clk   (sys_clk),
    .en    (map_en),
    .code  (code_q),
    .ascii (map_ascii)
  );

  assign is_shift = (code_q == SC_LSHIFT) || (code_q == SC_RSHIFT);
  assign is_ctrl  = (code_q == SC_CTRL);
  assign is_caps  = (code_q == SC_CAPS);
  assign is_mod   = is_shift || is_ctrl || is_caps;

  // Decoder FSM: next state, modifiers and the event to push.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    brk_d         = brk_q;
    ext_d         = ext_q;
    shift_d       = shift_q;
    ctrl_d        = ctrl_q;
    caps_d        = caps_q;
    code_next_n_d = code_next_n_q;
    map_en        = 1'b0;
    push_req      = 1'b0;
    ev_ascii      = 8'h00;
    ev_word       = '0;
    case (state_q)
      S_IDLE: if (code_ready) begin
        code_d        = code_data;
        code_next_n_d = 1'b0;
        state_d       = S_ACK;
      end
      S_ACK: begin
        code_next_n_d = 1'b1;
        if (code_q == SC_BREAK) begin
          brk_d   = 1'b1;
          state_d = S_IDLE;
        end else if (code_q == SC_EXT) begin
          ext_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          map_en  = 1'b1;
          state_d = S_LOOK;
        end
      end
      S_LOOK: state_d = S_EMIT;
      S_EMIT: begin
        // Event uses the modifier state before this key's own update;
        // modifier keys never push, so that is the state the user sees.
        ev_ascii = xform_ascii(map_ascii, shift_q, ctrl_q, caps_q);
        ev_word  = {caps_q, ctrl_q, shift_q, ext_q, brk_q, ev_ascii};
        if (is_shift)          shift_d = !brk_q;
        if (is_ctrl)           ctrl_d  = !brk_q;
        if (is_caps && !brk_q) caps_d  = !caps_q;
`ifdef KEY_BREAK_EVENTS_EN
        push_req = !is_mod && (map_ascii != 8'h00);
`else
        push_req = !brk_q && !is_mod && (map_ascii != 8'h00);
`endif
        brk_d   = 1'b0;
        ext_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control. The head is registered; its next value comes from the
  // entry behind the one being popped, or the pushed word when that
  // entry would otherwise be empty.
  always_comb begin
    pop        = ev_if.ev_ready && (count_q != '0);
    push_ok    = push_req && ((count_q != CW'(FIFO_DEPTH)) || pop);
    overflow_d = overflow_q || (push_req && !push_ok);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_next    = rd_ptr_q + AW'(1);
    rd_ptr_d   = pop ? rd_next : rd_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    valid_d    = (count_d != '0);
    head_d     = head_q;
    if (pop) begin
      if (count_q > CW'(1)) head_d = mem[rd_next];
      else if (push_ok)     head_d = ev_word;
      else                  head_d = '0;
    end else if (count_q == '0) begin
      head_d = push_ok ? ev_word : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!clrn) begin
      state_q       <= S_IDLE;
      code_q        <= 8'h00;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      shift_q       <= 1'b0;
      ctrl_q        <= 1'b0;
      caps_q        <= 1'b0;
      code_next_n_q <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_q        <= '0;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      shift_q       <= shift_d;
      ctrl_q        <= ctrl_d;
      caps_q        <= caps_d;
      code_next_n_q <= code_next_n_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_q        <= head_d;
      valid_q       <= valid_d;
      overflow_q    <= overflow_d;
    end
  end

  // NOTE: storage array has no reset; emptiness is tracked by count/pointers.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr_q] <= ev_word;
  end

  assign code_next_n    = code_next_n_q;
  assign ev_if.ev_data  = OUT_W'(head_q);
  assign ev_if.ev_valid = valid_q;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  assign caps_lock      = caps_q;

endmodule
